// File: rtl/fb_pkg.sv
// Shared types and constants for the ping-pong frame buffer.
// Optional build macro used by this slice: FB_OUT_REG_EN (extra read output register).
package fb_pkg;

    typedef enum logic {
        FB_WRITE = 1'b0,
        FB_FULL  = 1'b1
    } fb_state_e;

    localparam int                  REPEAT_W   = 8;
    localparam logic [REPEAT_W-1:0] REPEAT_MAX = '1;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_FRAME_W = 320;
    localparam int DEF_FRAME_H = 240;

    // Pixel-index width; a one-pixel frame still needs a one-bit index
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer_pp_if.sv
// Producer/display-side bundle of the ping-pong frame buffer.
// slave is the buffer itself, master is whoever drives pixels, reads and vsync.
interface frame_buffer_pp_if
    import fb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H
);
    localparam int N = FRAME_W * FRAME_H;
    localparam int A = addr_width(N);

    logic                wr_valid_i;
    logic                wr_ready_o;
    logic [DATA_W-1:0]   wr_data_i;
    logic                rd_req_i;
    logic [A-1:0]        rd_addr_i;
    logic                rd_valid_o;
    logic [DATA_W-1:0]   rd_data_o;
    logic                vsync_i;
    logic                swap_o;
    logic                bank_o;
    logic [REPEAT_W-1:0] repeat_cnt_o;

    modport master (
        output wr_valid_i, wr_data_i, rd_req_i, rd_addr_i, vsync_i,
        input  wr_ready_o, rd_valid_o, rd_data_o, swap_o, bank_o, repeat_cnt_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, rd_req_i, rd_addr_i, vsync_i,
        output wr_ready_o, rd_valid_o, rd_data_o, swap_o, bank_o, repeat_cnt_o
    );

endinterface

// File: rtl/fb_ram_sdp.sv
// Simple dual-port pixel RAM holding both banks; the bank select is the address MSB.
// One write port and one registered read port whose output register resets to zero.
module fb_ram_sdp #(
    parameter int DATA_W = 8,
    parameter int N      = 76800,
    parameter int A      = 17
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [A:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [A:0]        raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Two banks of exactly N pixels; callers never present an index >= N
    logic [DATA_W-1:0] mem [2][N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i[A]][waddr_i[A-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[raddr_i[A]][raddr_i[A-1:0]];
        end
    end

endmodule

// File: rtl/frame_buffer_pp.sv
// Ping-pong frame buffer: raster writes fill the back bank, random reads hit the front bank,
// and banks swap only on vsync after a full frame. FB_OUT_REG_EN adds a read output stage.
module frame_buffer_pp
    import fb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    frame_buffer_pp_if.slave  bus
);

    localparam int            N    = FRAME_W * FRAME_H;
    localparam int            A    = addr_width(N);
    localparam logic [A-1:0]  LAST = A'(N - 1);

    fb_state_e           state_q, state_d;
    logic [A-1:0]        wr_cnt_q, wr_cnt_d;
    logic                bank_q, bank_d;
    logic                swap_q, swap_d;
    logic [REPEAT_W-1:0] repeat_q, repeat_d;
    logic                ready_q;
    logic                wr_accept;
    logic                rd_in_range;
    logic                rd_valid_q;
    logic                rd_oob_q;
    logic [DATA_W-1:0]   ram_rdata;
    logic [DATA_W-1:0]   rd_data_mux;

    assign wr_accept   = bus.wr_valid_i && ready_q;
    assign rd_in_range = (A+1)'(bus.rd_addr_i) < (A+1)'(N);

    // A vsync that lands on the final-pixel accept sees WRITE, so it counts as a repeat
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        bank_d   = bank_q;
        swap_d   = 1'b0;
        repeat_d = repeat_q;

        if (wr_accept) begin
            wr_cnt_d = (wr_cnt_q == LAST) ? '0 : wr_cnt_q + 1'b1;
        end

        unique case (state_q)
            FB_WRITE: begin
                if (bus.vsync_i && (repeat_q != REPEAT_MAX)) begin
                    repeat_d = repeat_q + 1'b1;
                end
                if (wr_accept && (wr_cnt_q == LAST)) begin
                    state_d = FB_FULL;
                end
            end
            FB_FULL: begin
                if (bus.vsync_i) begin
                    bank_d  = ~bank_q;
                    swap_d  = 1'b1;
                    state_d = FB_WRITE;
                end
            end
            default: state_d = FB_WRITE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= FB_WRITE;
            wr_cnt_q <= '0;
            bank_q   <= 1'b0;
            swap_q   <= 1'b0;
            repeat_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            bank_q   <= bank_d;
            swap_q   <= swap_d;
            repeat_q <= repeat_d;
            ready_q  <= (state_d == FB_WRITE);
        end
    end

    fb_ram_sdp #(
        .DATA_W (DATA_W),
        .N      (N),
        .A      (A)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_accept),
        .waddr_i ({bank_q, wr_cnt_q}),
        .wdata_i (bus.wr_data_i),
        .re_i    (bus.rd_req_i && rd_in_range),
        .raddr_i ({~bank_q, bus.rd_addr_i}),
        .rdata_o (ram_rdata)
    );

    // Out-of-range reads skip the RAM and are forced to zero on the way out
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req_i;
            rd_oob_q   <= bus.rd_req_i && !rd_in_range;
        end
    end

    assign rd_data_mux = rd_oob_q ? '0 : ram_rdata;

`ifdef FB_OUT_REG_EN
    logic              rd_valid_q2;
    logic [DATA_W-1:0] rd_data_q2;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q2 <= 1'b0;
            rd_data_q2  <= '0;
        end else begin
            rd_valid_q2 <= rd_valid_q;
            rd_data_q2  <= rd_data_mux;
        end
    end

    assign bus.rd_valid_o = rd_valid_q2;
    assign bus.rd_data_o  = rd_data_q2;
`else
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_mux;
`endif

    assign bus.wr_ready_o   = ready_q;
    assign bus.swap_o       = swap_q;
    assign bus.bank_o       = bank_q;
    assign bus.repeat_cnt_o = repeat_q;

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Self-checking bench for frame_buffer_pp: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_frame_buffer_pp;
    import fb_pkg::*;

    localparam int DW  = 8;
    localparam int FW  = 4;
    localparam int FH  = 2;
    localparam int N   = FW * FH;
    localparam int A   = 3;
    localparam int FW2 = 3;
    localparam int N2  = FW2 * FH;
`ifdef FB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    frame_buffer_pp_if #(.DATA_W(DW), .FRAME_W(FW),  .FRAME_H(FH)) bus  ();
    frame_buffer_pp_if #(.DATA_W(DW), .FRAME_W(FW2), .FRAME_H(FH)) bus2 ();

    frame_buffer_pp #(.DATA_W(DW), .FRAME_W(FW), .FRAME_H(FH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Second, non-power-of-two frame so that indices >= N are representable
    frame_buffer_pp #(.DATA_W(DW), .FRAME_W(FW2), .FRAME_H(FH)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus2)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit v, input logic [7:0] d, input bit req,
                                  input logic [A-1:0] addr, input bit vs);
        bus.wr_valid_i = v;
        bus.wr_data_i  = d;
        bus.rd_req_i   = req;
        bus.rd_addr_i  = addr;
        bus.vsync_i    = vs;
        @(negedge clk);
    endtask

    task automatic apply_stimulus2(input bit v, input logic [7:0] d, input bit req,
                                   input logic [A-1:0] addr, input bit vs);
        bus2.wr_valid_i = v;
        bus2.wr_data_i  = d;
        bus2.rd_req_i   = req;
        bus2.rd_addr_i  = addr;
        bus2.vsync_i    = vs;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0, '0, 1'b0);
    endtask

    // Reference model: two frame stores, a fill count and a "frame pending" flag
    logic [7:0]  mem_m   [2][N];
    bit          known_m [2][N];
    int          cnt_m, rep_m;
    bit          full_m, bank_m, swap_m, ready_m;
    bit          v1_m, v2_m, k1_m, k2_m;
    logic [7:0]  d1_m, d2_m;
    logic [7:0]  rd_log[$];
    logic [7:0]  rd_log2[$];
    bit          exp_v, exp_k, new_full;
    logic [7:0]  exp_d;
    int          addr_m;

    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_m = 0; rep_m = 0; full_m = 0; bank_m = 0; swap_m = 0; ready_m = 0;
            v1_m = 0; v2_m = 0; k1_m = 1; k2_m = 1; d1_m = 8'h00; d2_m = 8'h00;
        end else begin
            v2_m = v1_m; d2_m = d1_m; k2_m = k1_m;
            v1_m = bus.rd_req_i;
            if (bus.rd_req_i) begin
                addr_m = int'(bus.rd_addr_i);
                if (addr_m >= N) begin
                    d1_m = 8'h00; k1_m = 1;
                end else begin
                    d1_m = mem_m[!bank_m][addr_m];
                    k1_m = known_m[!bank_m][addr_m];
                end
            end
            new_full = 0;
            if (bus.wr_valid_i && ready_m) begin
                mem_m[bank_m][cnt_m]   = bus.wr_data_i;
                known_m[bank_m][cnt_m] = 1;
                cnt_m++;
                if (cnt_m == N) begin
                    cnt_m = 0; new_full = 1;
                end
            end
            swap_m = 0;
            if (bus.vsync_i) begin
                if (full_m) begin
                    bank_m = !bank_m; swap_m = 1; full_m = 0;
                end else if (rep_m < 255) begin
                    rep_m++;
                end
            end
            full_m  = full_m || new_full;
            ready_m = !full_m;
        end
        exp_v = (LAT == 1) ? v1_m : v2_m;
        exp_d = (LAT == 1) ? d1_m : d2_m;
        exp_k = (LAT == 1) ? k1_m : k2_m;
        #1;
        check_output("m_ready", bus.wr_ready_o, ready_m);
        check_output("m_bank", bus.bank_o, bank_m);
        check_output("m_swap", bus.swap_o, swap_m);
        check_output("m_repeat", bus.repeat_cnt_o, rep_m);
        check_output("m_rd_valid", bus.rd_valid_o, exp_v);
        if (exp_v && exp_k) check_output("m_rd_data", bus.rd_data_o, exp_d);
        if (bus.rd_valid_o) rd_log.push_back(bus.rd_data_o);
        if (bus2.rd_valid_o) rd_log2.push_back(bus2.rd_data_o);
    end

    initial begin
        rst_n = 1'b0;
        bus.wr_valid_i = 0; bus.wr_data_i = 0; bus.rd_req_i = 0; bus.rd_addr_i = 0; bus.vsync_i = 0;
        bus2.wr_valid_i = 0; bus2.wr_data_i = 0; bus2.rd_req_i = 0; bus2.rd_addr_i = 0; bus2.vsync_i = 0;
        repeat (3) @(negedge clk);
        check_output("rst_ready", bus.wr_ready_o, 0);
        check_output("rst_rd_data", bus.rd_data_o, 0);

        // 1: release and idle
        rst_n = 1'b1;
        idle(1);
        check_output("t1_ready", bus.wr_ready_o, 1);
        check_output("t1_bank", bus.bank_o, 0);
        check_output("t1_rd_valid", bus.rd_valid_o, 0);
        check_output("t1_repeat", bus.repeat_cnt_o, 0);

        // 2: first frame, swap, read back
        for (int i = 0; i < N; i++) apply_stimulus(1'b1, 8'(8'h10 + i), 1'b0, '0, 1'b0);
        check_output("t2_full_ready", bus.wr_ready_o, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, '0, 1'b1);
        check_output("t2_swap", bus.swap_o, 1);
        check_output("t2_bank", bus.bank_o, 1);
        idle(1);
        check_output("t2_swap_end", bus.swap_o, 0);
        check_output("t2_ready", bus.wr_ready_o, 1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 3'd3, 1'b0);
        idle(LAT - 1);
        check_output("t2_rd_valid", bus.rd_valid_o, 1);
        check_output("t2_rd_data", bus.rd_data_o, 8'h13);
        idle(2);

        // 3: repeated frames
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'h00, 1'b0, '0, 1'b1);
        check_output("t3_repeat3", bus.repeat_cnt_o, 3);
        check_output("t3_bank", bus.bank_o, 1);
        for (int i = 0; i < 300; i++) apply_stimulus(1'b0, 8'h00, 1'b0, '0, 1'b1);
        check_output("t3_repeat_sat", bus.repeat_cnt_o, 255);

        // 4: read on the swapping vsync sees the old front bank
        for (int i = 0; i < N; i++) apply_stimulus(1'b1, 8'(8'h20 + i), 1'b0, '0, 1'b0);
        rd_log.delete();
        apply_stimulus(1'b0, 8'h00, 1'b1, 3'd5, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 3'd5, 1'b0);
        idle(3);
        check_output("t4_count", rd_log.size(), 2);
        check_output("t4_pre_swap", rd_log[0], 8'h15);
        check_output("t4_post_swap", rd_log[1], 8'h25);
        check_output("t4_bank", bus.bank_o, 0);

        // 6: reset after 5 pixels discards the partial frame
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'h40 + i), 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check_output("t6_repeat_clr", bus.repeat_cnt_o, 0);
        for (int i = 0; i < N; i++) apply_stimulus(1'b1, 8'(8'h30 + i), 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, '0, 1'b1);
        rd_log.delete();
        for (int i = 0; i < N; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 3'(i), 1'b0);
        idle(3);
        check_output("t6_count", rd_log.size(), N);
        for (int i = 0; i < N; i++) check_output($sformatf("t6_addr%0d", i), rd_log[i], 8'(8'h30 + i));

        // 5: out-of-range index on the 6-pixel instance
        for (int i = 0; i < N2; i++) apply_stimulus2(1'b1, 8'(8'h50 + i), 1'b0, '0, 1'b0);
        apply_stimulus2(1'b0, 8'h00, 1'b0, '0, 1'b1);
        rd_log2.delete();
        apply_stimulus2(1'b0, 8'h00, 1'b1, 3'd1, 1'b0);
        apply_stimulus2(1'b0, 8'h00, 1'b1, 3'd6, 1'b0);
        apply_stimulus2(1'b0, 8'h00, 1'b1, 3'd7, 1'b0);
        apply_stimulus2(1'b0, 8'h00, 1'b0, '0, 1'b0);
        apply_stimulus2(1'b0, 8'h00, 1'b0, '0, 1'b0);
        apply_stimulus2(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check_output("t5_count", rd_log2.size(), 3);
        check_output("t5_in_range", rd_log2[0], 8'h51);
        check_output("t5_oob6", rd_log2[1], 8'h00);
        check_output("t5_oob7", rd_log2[2], 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            apply_stimulus(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                           3'($urandom), 1'($urandom_range(0, 9) == 0));
        end
        rst_n = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
